ascon_sequencer: RTL and testbench

Control FSM for the Ascon-128a AEAD encryption datapath built around the one-round-per-cycle permutation loop. It drives the loop's mux select, round index, state-register enable, begin/end XOR bypass codes and cipher/tag capture enables. It also runs a valid/ready handshake for 128-bit AD and plaintext blocks presented on the shared `data_i` bus. It sits between the top-level I/O wrapper and the permutation datapath, one instance per core.

---
 rtl/ascon_sequencer_if.sv | 19 +
 rtl/ascon_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ascon_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_sequencer_if.sv
// Block handshake between the upstream I/O wrapper and the Ascon sequencer.
// The wrapper is the master; the sequencer consumes blocks as the slave.
interface ascon_sequencer_if;
  logic data_valid_i;
  logic data_last_i;
  logic data_ready_o;

  modport master (
    output data_valid_i,
    output data_last_i,
    input  data_ready_o
  );

  modport slave (
    input  data_valid_i,
    input  data_last_i,
    output data_ready_o
  );
endinterface

// File: rtl/ascon_sequencer.sv
// Control FSM for the one-round-per-cycle Ascon-128a encryption datapath:
// sequences init, AD, PT and finalization permutations and the block handshake.
module ascon_sequencer #(
  parameter int unsigned PA_ROUNDS = 12,
  parameter int unsigned PB_ROUNDS = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     ad_present_i,
  ascon_sequencer_if.slave         data_if,
  output logic                     input_mode_o,
  output logic [3:0]               round_o,
  output logic                     enable_o,
  output logic [1:0]               bypass_xor_begin_o,
  output logic [1:0]               bypass_xor_end_o,
  output logic                     en_reg_cipher_o,
  output logic                     en_reg_tag_o,
  output logic                     cipher_valid_o,
  output logic                     tag_valid_o,
  output logic                     busy_o
);

  // Round indices always end at 11; shorter permutations start later.
  localparam logic [3:0] LastRound = 4'd11;
  localparam logic [3:0] PaStart   = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] PbStart   = 4'(12 - PB_ROUNDS);

  typedef enum logic [2:0] {
    StIdle, StInit, StWaitAd, StAd, StWaitPt, StPt, StFinal, StDone
  } state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_rc, w_rc_next;
  logic       r_ad_present, w_ad_present_next;
  logic       r_last, w_last_next;
  logic       r_cipher_valid;

  logic       w_ready, w_input_mode, w_enable, w_en_cipher, w_en_tag, w_tag_valid, w_busy;
  logic [3:0] w_round;
  logic [1:0] w_begin, w_end;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state        <= StIdle;
      r_rc           <= '0;
      r_ad_present   <= 1'b0;
      r_last         <= 1'b0;
      r_cipher_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_rc           <= w_rc_next;
      r_ad_present   <= w_ad_present_next;
      r_last         <= w_last_next;
      r_cipher_valid <= w_en_cipher;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_rc_next         = r_rc;
    w_ad_present_next = r_ad_present;
    w_last_next       = r_last;
    w_ready           = 1'b0;
    w_input_mode      = 1'b0;
    w_round           = '0;
    w_enable          = 1'b0;
    w_begin           = 2'b00;
    w_end             = 2'b00;
    w_en_cipher       = 1'b0;
    w_en_tag          = 1'b0;
    w_tag_valid       = 1'b0;
    w_busy            = (r_state != StIdle);

    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_next      = StInit;
          w_rc_next         = PaStart;
          w_ad_present_next = ad_present_i;
        end
      end
      StInit: begin
        w_enable     = 1'b1;
        w_round      = r_rc;
        w_input_mode = (r_rc == PaStart);
        if (r_rc == LastRound) begin
          w_end        = r_ad_present ? 2'b01 : 2'b11;
          w_state_next = r_ad_present ? StWaitAd : StWaitPt;
        end else begin
          w_rc_next = r_rc + 4'd1;
        end
      end
      StWaitAd: begin
        w_ready = 1'b1;
        if (data_if.data_valid_i) begin
          w_enable     = 1'b1;
          w_begin      = 2'b01;
          w_round      = PbStart;
          w_last_next  = data_if.data_last_i;
          w_state_next = StAd;
          w_rc_next    = PbStart + 4'd1;
        end
      end
      StWaitPt: begin
        w_ready = 1'b1;
        if (data_if.data_valid_i) begin
          w_enable    = 1'b1;
          w_en_cipher = 1'b1;
          w_last_next = data_if.data_last_i;
          // The last PT block absorbs the key and runs the full finalization.
          if (data_if.data_last_i) begin
            w_begin      = 2'b11;
            w_round      = PaStart;
            w_state_next = StFinal;
            w_rc_next    = PaStart + 4'd1;
          end else begin
            w_begin      = 2'b01;
            w_round      = PbStart;
            w_state_next = StPt;
            w_rc_next    = PbStart + 4'd1;
          end
        end
      end
      StAd, StPt: begin
        w_enable = 1'b1;
        w_round  = r_rc;
        if (r_rc == LastRound) begin
          if (r_state == StAd && r_last) begin
            w_end        = 2'b10;
            w_state_next = StWaitPt;
          end else begin
            w_state_next = (r_state == StAd) ? StWaitAd : StWaitPt;
          end
        end else begin
          w_rc_next = r_rc + 4'd1;
        end
      end
      StFinal: begin
        w_enable = 1'b1;
        w_round  = r_rc;
        if (r_rc == LastRound) begin
          w_end        = 2'b01;
          w_en_tag     = 1'b1;
          w_state_next = StDone;
        end else begin
          w_rc_next = r_rc + 4'd1;
        end
      end
      StDone: begin
        w_tag_valid  = 1'b1;
        w_state_next = StIdle;
        w_rc_next    = '0;
      end
      default: begin
        w_state_next = StIdle;
        w_rc_next    = '0;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, even mid-permutation.
    if (reset_i) begin
      w_ready      = 1'b0;
      w_input_mode = 1'b0;
      w_round      = '0;
      w_enable     = 1'b0;
      w_begin      = 2'b00;
      w_end        = 2'b00;
      w_en_cipher  = 1'b0;
      w_en_tag     = 1'b0;
      w_tag_valid  = 1'b0;
      w_busy       = 1'b0;
    end
  end

  assign data_if.data_ready_o = w_ready;
  assign input_mode_o         = w_input_mode;
  assign round_o              = w_round;
  assign enable_o             = w_enable;
  assign bypass_xor_begin_o   = w_begin;
  assign bypass_xor_end_o     = w_end;
  assign en_reg_cipher_o      = w_en_cipher;
  assign en_reg_tag_o         = w_en_tag;
  assign cipher_valid_o       = r_cipher_valid & ~reset_i;
  assign tag_valid_o          = w_tag_valid;
  assign busy_o               = w_busy;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Directed bench for ascon_sequencer: cycle-accurate control traces with
// hand-derived expected timing for each message shape.
module tb_ascon_sequencer;
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       ad_present_i = 1'b0;
  logic       input_mode_o, enable_o, en_reg_cipher_o, en_reg_tag_o;
  logic       cipher_valid_o, tag_valid_o, busy_o;
  logic [3:0] round_o;
  logic [1:0] bypass_xor_begin_o, bypass_xor_end_o;

  int n_cmp = 0;
  int n_err = 0;

  ascon_sequencer_if u_if ();

  ascon_sequencer u_dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .ad_present_i       (ad_present_i),
    .data_if            (u_if),
    .input_mode_o       (input_mode_o),
    .round_o            (round_o),
    .enable_o           (enable_o),
    .bypass_xor_begin_o (bypass_xor_begin_o),
    .bypass_xor_end_o   (bypass_xor_end_o),
    .en_reg_cipher_o    (en_reg_cipher_o),
    .en_reg_tag_o       (en_reg_tag_o),
    .cipher_valid_o     (cipher_valid_o),
    .tag_valid_o        (tag_valid_o),
    .busy_o             (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // After this returns, the DUT is in the first INIT cycle (cycle 0).
  task automatic kick(input logic ad);
    start_i      = 1'b1;
    ad_present_i = ad;
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b1;
    @(negedge clock_i);
    n_cmp++;
    if ({busy_o, u_if.data_ready_o, enable_o, tag_valid_o} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000",
               {busy_o, u_if.data_ready_o, enable_o, tag_valid_o});
    end
    step();
    start_i = 1'b0;
    reset_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if ({busy_o, u_if.data_ready_o, enable_o, input_mode_o, round_o} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_start_priority: got %h want 00",
               {busy_o, u_if.data_ready_o, enable_o, input_mode_o, round_o});
    end
    step();
  endtask

  task automatic test_no_ad();
    int tag_c = -1;
    do_reset();
    u_if.data_valid_i = 1'b1;
    u_if.data_last_i  = 1'b1;
    kick(1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clock_i);
      if (c <= 11) begin
        n_cmp++;
        if ({enable_o, input_mode_o, round_o, u_if.data_ready_o} !==
            {1'b1, (c == 0), 4'(c), 1'b0}) begin
          n_err++;
          $display("FAIL init_c%0d: got en/im/rnd/rdy %b want %b", c,
                   {enable_o, input_mode_o, round_o, u_if.data_ready_o},
                   {1'b1, (c == 0), 4'(c), 1'b0});
        end
        n_cmp++;
        if (bypass_xor_end_o !== ((c == 11) ? 2'b11 : 2'b00)) begin
          n_err++;
          $display("FAIL init_end_c%0d: got %b want %b", c, bypass_xor_end_o,
                   (c == 11) ? 2'b11 : 2'b00);
        end
      end
      if (c == 12) begin
        n_cmp++;
        if ({u_if.data_ready_o, enable_o, bypass_xor_begin_o, en_reg_cipher_o, round_o} !==
            {1'b1, 1'b1, 2'b11, 1'b1, 4'd0}) begin
          n_err++;
          $display("FAIL last_pt_handshake: got %b want %b",
                   {u_if.data_ready_o, enable_o, bypass_xor_begin_o, en_reg_cipher_o, round_o},
                   {1'b1, 1'b1, 2'b11, 1'b1, 4'd0});
        end
      end
      if (c == 13) begin
        n_cmp++;
        if ({cipher_valid_o, round_o, u_if.data_ready_o} !== {1'b1, 4'd1, 1'b0}) begin
          n_err++;
          $display("FAIL final_first: got %b want 100010",
                   {cipher_valid_o, round_o, u_if.data_ready_o});
        end
      end
      if (c == 23) begin
        n_cmp++;
        if ({en_reg_tag_o, bypass_xor_end_o, round_o} !== {1'b1, 2'b01, 4'd11}) begin
          n_err++;
          $display("FAIL final_last: got %b want 1011011",
                   {en_reg_tag_o, bypass_xor_end_o, round_o});
        end
      end
      if (c == 25) begin
        n_cmp++;
        if (busy_o !== 1'b0) begin
          n_err++;
          $display("FAIL idle_after_done: got busy %b want 0", busy_o);
        end
      end
      if (tag_valid_o === 1'b1 && tag_c < 0) tag_c = c;
      step();
    end
    n_cmp++;
    if (tag_c != 24) begin
      n_err++;
      $display("FAIL no_ad_tag_cycle: got %0d want 24", tag_c);
    end
    u_if.data_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ends[$];
    int end_cs[$];
    int n_cv  = 0;
    int tag_c = -1;
    do_reset();
    u_if.data_valid_i = 1'b1;
    kick(1'b1);
    for (int c = 0; c < 70; c++) begin
      u_if.data_last_i = (c == 20 || c == 44);
      @(negedge clock_i);
      if (bypass_xor_end_o !== 2'b00) begin
        ends.push_back(int'(bypass_xor_end_o));
        end_cs.push_back(c);
      end
      if (cipher_valid_o === 1'b1) n_cv++;
      if (tag_valid_o === 1'b1 && tag_c < 0) tag_c = c;
      if (c == 20) begin
        n_cmp++;
        if ({bypass_xor_begin_o, round_o, en_reg_cipher_o} !== {2'b01, 4'd4, 1'b0}) begin
          n_err++;
          $display("FAIL ad2_handshake: got %b want 0101000",
                   {bypass_xor_begin_o, round_o, en_reg_cipher_o});
        end
      end
      if (c == 21) begin
        n_cmp++;
        if ({round_o, u_if.data_ready_o} !== {4'd5, 1'b0}) begin
          n_err++;
          $display("FAIL ad2_round5: got %b want 01010", {round_o, u_if.data_ready_o});
        end
      end
      if (c == 44) begin
        n_cmp++;
        if ({bypass_xor_begin_o, round_o, en_reg_cipher_o} !== {2'b11, 4'd0, 1'b1}) begin
          n_err++;
          $display("FAIL pt3_handshake: got %b want 1100001",
                   {bypass_xor_begin_o, round_o, en_reg_cipher_o});
        end
      end
      step();
    end
    n_cmp++;
    if (ends.size() != 3) begin
      n_err++;
      $display("FAIL b2b_end_count: got %0d want 3", ends.size());
    end else begin
      n_cmp++;
      if (ends[0] != 1 || ends[1] != 2 || ends[2] != 1) begin
        n_err++;
        $display("FAIL b2b_end_codes: got %0d %0d %0d want 1 2 1", ends[0], ends[1], ends[2]);
      end
      n_cmp++;
      if (end_cs[0] != 11 || end_cs[1] != 27 || end_cs[2] != 55) begin
        n_err++;
        $display("FAIL b2b_end_cycles: got %0d %0d %0d want 11 27 55",
                 end_cs[0], end_cs[1], end_cs[2]);
      end
    end
    n_cmp++;
    if (n_cv != 3) begin
      n_err++;
      $display("FAIL b2b_cipher_pulses: got %0d want 3", n_cv);
    end
    n_cmp++;
    if (tag_c != 56) begin
      n_err++;
      $display("FAIL b2b_tag_cycle: got %0d want 56", tag_c);
    end
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
  endtask

  task automatic test_stall();
    int tag_c = -1;
    do_reset();
    kick(1'b0);
    for (int c = 0; c < 40; c++) begin
      // Five stall cycles with last asserted but no valid.
      u_if.data_valid_i = (c >= 17);
      u_if.data_last_i  = (c >= 12);
      @(negedge clock_i);
      if (c >= 12 && c <= 16) begin
        n_cmp++;
        if ({enable_o, u_if.data_ready_o, busy_o, en_reg_cipher_o} !== 4'b0110) begin
          n_err++;
          $display("FAIL stall_c%0d: got en/rdy/busy/cip %b want 0110", c,
                   {enable_o, u_if.data_ready_o, busy_o, en_reg_cipher_o});
        end
      end
      if (c == 17) begin
        n_cmp++;
        if ({enable_o, bypass_xor_begin_o, round_o} !== {1'b1, 2'b11, 4'd0}) begin
          n_err++;
          $display("FAIL stall_release: got %b want 1110000",
                   {enable_o, bypass_xor_begin_o, round_o});
        end
      end
      if (tag_valid_o === 1'b1 && tag_c < 0) tag_c = c;
      step();
    end
    n_cmp++;
    if (tag_c != 29) begin
      n_err++;
      $display("FAIL stall_tag_cycle: got %0d want 29", tag_c);
    end
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
  endtask

  task automatic test_start_ignored();
    int tag_c = -1;
    int n_im  = 0;
    int n_cv  = 0;
    do_reset();
    u_if.data_valid_i = 1'b1;
    kick(1'b0);
    for (int c = 0; c < 40; c++) begin
      u_if.data_last_i = (c == 20);
      start_i = (c == 15);
      @(negedge clock_i);
      if (input_mode_o === 1'b1) n_im++;
      if (cipher_valid_o === 1'b1) n_cv++;
      if (tag_valid_o === 1'b1 && tag_c < 0) tag_c = c;
      if (c == 16) begin
        n_cmp++;
        if ({busy_o, round_o, input_mode_o} !== {1'b1, 4'd8, 1'b0}) begin
          n_err++;
          $display("FAIL start_mid_pt: got %b want 1010000", {busy_o, round_o, input_mode_o});
        end
      end
      step();
    end
    start_i = 1'b0;
    n_cmp++;
    if (n_im != 1) begin
      n_err++;
      $display("FAIL start_ignored_init_count: got %0d want 1", n_im);
    end
    n_cmp++;
    if (n_cv != 2) begin
      n_err++;
      $display("FAIL start_ignored_cipher_count: got %0d want 2", n_cv);
    end
    n_cmp++;
    if (tag_c != 32) begin
      n_err++;
      $display("FAIL start_ignored_tag_cycle: got %0d want 32", tag_c);
    end
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
  endtask

  task automatic test_reset_mid_ad();
    do_reset();
    u_if.data_valid_i = 1'b1;
    u_if.data_last_i  = 1'b0;
    kick(1'b1);
    repeat (15) step();
    @(negedge clock_i);
    n_cmp++;
    if ({busy_o, round_o, enable_o} !== {1'b1, 4'd7, 1'b1}) begin
      n_err++;
      $display("FAIL ad_rc7: got %b want 101111", {busy_o, round_o, enable_o});
    end
    reset_i = 1'b1;
    @(negedge clock_i);
    n_cmp++;
    if ({busy_o, enable_o, round_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_during_ad: got %b want 000000", {busy_o, enable_o, round_o});
    end
    step();
    reset_i = 1'b0;
    @(negedge clock_i);
    n_cmp++;
    if ({busy_o, u_if.data_ready_o, enable_o, round_o, cipher_valid_o} !== 8'h00) begin
      n_err++;
      $display("FAIL after_reset_idle: got %b want 00000000",
               {busy_o, u_if.data_ready_o, enable_o, round_o, cipher_valid_o});
    end
    kick(1'b0);
    @(negedge clock_i);
    n_cmp++;
    if ({input_mode_o, round_o, enable_o, busy_o} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL restart_after_reset: got %b want 1000011",
               {input_mode_o, round_o, enable_o, busy_o});
    end
    u_if.data_valid_i = 1'b0;
    do_reset();
  endtask

  initial begin
    u_if.data_valid_i = 1'b0;
    u_if.data_last_i  = 1'b0;
    step();
    test_reset();
    test_no_ad();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_reset_mid_ad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
